ramio_port_tester: RTL

RAMIO_PORT_TESTER -- requirements
Module: ramio_port_tester

---
 rtl/ramio_port_tester.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ramio_port_tester.sv
// Self-running write/read-back tester for a RAMIO-style memory port.
// Writes a seeded pattern with mixed access sizes, then reads it back and compares.
module ramio_port_tester #(
  parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
  parameter int          WORD_COUNT = 16,
  parameter logic [31:0] SEED       = 32'h80FF_7F01,
  parameter int          TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        enA,
  output logic [1:0]  weA,
  output logic [2:0]  reA,
  output logic [31:0] addrA,
  output logic [31:0] dinA,
  input  logic [31:0] doutA,
  input  logic        validA,
  input  logic        bsyA,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] err_addr,
  output logic [31:0] err_exp,
  output logic [31:0] err_act
);

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
  localparam logic [31:0] TLIM     = 32'(TIMEOUT - 1);
  localparam logic [31:0] PSTEP    = 32'h0101_0101;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CHECK, FINISH
  } state_t;

  state_t      state, state_nx;
  logic        rd_phase;
  logic [15:0] idx;
  logic [1:0]  mode, step;
  logic [31:0] pat, base, rdata, tcnt;

  logic [1:0]  s_we;
  logic [2:0]  s_re;
  logic [31:0] s_addr, s_din, s_exp;
  logic        last_step, last_word;
  logic        xfer_done, tout, tmo_hit, miss;

  // Current step: mode cycles word/byte/half writes, reads are fixed
  always_comb begin
    s_we      = '0;
    s_re      = '0;
    s_addr    = base;
    s_din     = '0;
    s_exp     = pat;
    last_step = 1'b0;
    if (rd_phase) begin
      case (step)
        2'd0: s_re = 3'b111;
        2'd1: begin
          s_re   = 3'b101;
          s_addr = base + 32'd3;
          s_exp  = {{24{pat[31]}}, pat[31:24]};
        end
        default: begin
          s_re      = 3'b010;
          s_addr    = base + 32'd2;
          s_exp     = {16'h0, pat[31:16]};
          last_step = 1'b1;
        end
      endcase
    end else begin
      unique case (1'b1)
        mode == 2'd1: begin
          s_we      = 2'd1;
          s_addr    = base + {30'd0, step};
          s_din     = {24'h0, pat[{step, 3'b000} +: 8]};
          last_step = (step == 2'd3);
        end
        mode == 2'd2: begin
          s_we      = 2'd2;
          s_addr    = base + {29'd0, step[0], 1'b0};
          s_din     = {16'h0, step[0] ? pat[31:16] : pat[15:0]};
          last_step = step[0];
        end
        default: begin
          s_we      = 2'd3;
          s_din     = pat;
          last_step = 1'b1;
        end
      endcase
      s_exp = s_din;
    end
  end

  assign last_word = (idx == LAST_IDX);
  assign xfer_done = !bsyA && (!rd_phase || validA);
  assign tout      = (tcnt == TLIM);
  assign tmo_hit   = tout && ((state == ISSUE && bsyA) ||
                              (state == WAIT && !xfer_done));
  assign miss      = rd_phase && (rdata != s_exp);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = ISSUE;
      ISSUE:  if (!bsyA) state_nx = WAIT;
              else if (tmo_hit) state_nx = FINISH;
      WAIT:   if (xfer_done) state_nx = CHECK;
              else if (tmo_hit) state_nx = FINISH;
      CHECK:  if (miss || (rd_phase && last_step && last_word))
                state_nx = FINISH;
              else
                state_nx = ISSUE;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enA   = (state == ISSUE) && !bsyA;
  assign weA   = enA ? s_we : 2'd0;
  assign reA   = enA ? s_re : 3'd0;
  assign addrA = enA ? s_addr : 32'd0;
  assign dinA  = enA ? s_din : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      err_addr <= '0;
      err_exp  <= '0;
      err_act  <= '0;
      rd_phase <= 1'b0;
      idx      <= '0;
      mode     <= '0;
      step     <= '0;
      pat      <= '0;
      base     <= '0;
      rdata    <= '0;
      tcnt     <= '0;
    end else begin
      if (state_nx == ISSUE && state != ISSUE)
        tcnt <= '0;
      else if (state == ISSUE || state == WAIT)
        tcnt <= tcnt + 32'd1;
      if (tmo_hit) begin
        fail     <= 1'b1;
        timeout  <= 1'b1;
        err_addr <= s_addr;
        err_exp  <= s_exp;
        err_act  <= '0;
      end
      case (state)
        IDLE: if (start) begin
          busy     <= 1'b1;
          done     <= 1'b0;
          pass     <= 1'b0;
          fail     <= 1'b0;
          timeout  <= 1'b0;
          err_addr <= '0;
          err_exp  <= '0;
          err_act  <= '0;
          rd_phase <= 1'b0;
          idx      <= '0;
          mode     <= '0;
          step     <= '0;
          pat      <= SEED;
          base     <= ADDR_BASE;
        end
        WAIT: if (xfer_done) rdata <= doutA;
        CHECK: begin
          if (miss) begin
            fail     <= 1'b1;
            err_addr <= s_addr;
            err_exp  <= s_exp;
            err_act  <= rdata;
          end else if (last_step) begin
            step <= '0;
            if (!last_word) begin
              idx  <= idx + 16'd1;
              mode <= (mode == 2'd2) ? 2'd0 : mode + 2'd1;
              pat  <= pat + PSTEP;
              base <= base + 32'd4;
            end else if (!rd_phase) begin
              rd_phase <= 1'b1;
              idx      <= '0;
              mode     <= '0;
              pat      <= SEED;
              base     <= ADDR_BASE;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= ~fail;
        end
        default: ;
      endcase
    end
  end

endmodule
